// File: rtl/cpu_pkg.sv
// cpu_pkg: condition codes, NZCV bit positions and flag struct shared by the flag unit
package cpu_pkg;
  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, RESERVADO
  } cond_e;
  localparam int BIT_N = 3;
  localparam int BIT_Z = 2;
  localparam int BIT_C = 1;
  localparam int BIT_V = 0;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } banderas_t;
endpackage

// File: rtl/unidad_condicion_banderas_if.sv
// unidad_condicion_banderas_if: ALU-side input and writeback-side output handshake bundle
interface unidad_condicion_banderas_if #(parameter int N = 32);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] resultado;
  logic [3:0]   ban_in;
  logic [3:0]   cond;
  logic         actualiza_ban;
  logic         escribe_in;
  logic [3:0]   rd;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_resultado;
  logic [3:0]   out_rd;
  logic         out_escribe;
  logic [3:0]   banderas;
  logic [7:0]   anuladas;
  logic         cond_invalida;
  modport slave (
    input  in_valid, resultado, ban_in, cond, actualiza_ban, escribe_in, rd, out_ready,
    output in_ready, out_valid, out_resultado, out_rd, out_escribe, banderas, anuladas, cond_invalida
  );
  modport master (
    output in_valid, resultado, ban_in, cond, actualiza_ban, escribe_in, rd, out_ready,
    input  in_ready, out_valid, out_resultado, out_rd, out_escribe, banderas, anuladas, cond_invalida
  );
endinterface

// File: rtl/evaluador_condicion.sv
// evaluador_condicion: combinational decode of a condition code against NZCV flags
module evaluador_condicion
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] banderas,
  output logic       cumple
);
  logic n, z, c, v;
  assign n = banderas[BIT_N];
  assign z = banderas[BIT_Z];
  assign c = banderas[BIT_C];
  assign v = banderas[BIT_V];
  always_comb begin
    cumple = 1'b0;
    case (cond_e'(cond))
      EQ: cumple = z;
      NE: cumple = !z;
      CS: cumple = c;
      CC: cumple = !c;
      MI: cumple = n;
      PL: cumple = !n;
      VS: cumple = v;
      VC: cumple = !v;
      HI: cumple = c && !z;
      LS: cumple = !c || z;
      GE: cumple = n == v;
      LT: cumple = n != v;
      GT: cumple = !z && (n == v);
      LE: cumple = z || (n != v);
      AL: cumple = 1'b1;
      default: cumple = 1'b0;
    endcase
  end
endmodule

// File: rtl/unidad_condicion_banderas.sv
// unidad_condicion_banderas: one-entry pipeline stage that gates writes by condition and owns the NZCV register
module unidad_condicion_banderas
  import cpu_pkg::*;
#(
  parameter int N = 32
) (
  input logic clk,
  input logic rst_n,
  unidad_condicion_banderas_if.slave bus
);
  logic         in_ready, acc, cumple;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_resultado_q, out_resultado_d;
  logic [3:0]   out_rd_q, out_rd_d;
  logic         out_escribe_q, out_escribe_d;
  banderas_t    banderas_q, banderas_d;
  logic [7:0]   anuladas_q, anuladas_d;
  logic         cond_invalida_q, cond_invalida_d;
  evaluador_condicion u_eval (
    .cond    (bus.cond),
    .banderas(banderas_q),
    .cumple  (cumple)
  );
  // flags update at the accept edge, so the next accept already sees them
  always_comb begin
    in_ready        = !out_valid_q || bus.out_ready;
    acc             = bus.in_valid && in_ready;
    out_valid_d     = acc || (out_valid_q && !bus.out_ready);
    out_resultado_d = acc ? bus.resultado : out_resultado_q;
    out_rd_d        = acc ? bus.rd : out_rd_q;
    out_escribe_d   = acc ? bus.escribe_in && cumple : out_escribe_q;
    banderas_d      = acc && cumple && bus.actualiza_ban ? banderas_t'(bus.ban_in) : banderas_q;
    anuladas_d      = acc && !cumple && anuladas_q != 8'hFF ? anuladas_q + 8'd1 : anuladas_q;
    cond_invalida_d = cond_invalida_q || (acc && bus.cond == RESERVADO);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q     <= 1'b0;
      out_resultado_q <= '0;
      out_rd_q        <= '0;
      out_escribe_q   <= 1'b0;
      banderas_q      <= '0;
      anuladas_q      <= '0;
      cond_invalida_q <= 1'b0;
    end else begin
      out_valid_q     <= out_valid_d;
      out_resultado_q <= out_resultado_d;
      out_rd_q        <= out_rd_d;
      out_escribe_q   <= out_escribe_d;
      banderas_q      <= banderas_d;
      anuladas_q      <= anuladas_d;
      cond_invalida_q <= cond_invalida_d;
    end
  end
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_resultado = out_resultado_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_escribe   = out_escribe_q;
  assign bus.banderas      = banderas_q;
  assign bus.anuladas      = anuladas_q;
  assign bus.cond_invalida = cond_invalida_q;
endmodule

// File: tb/tb_unidad_condicion_banderas.sv
// tb_unidad_condicion_banderas: directed vector table plus hand sequences for backpressure, saturation and reset
module tb_unidad_condicion_banderas;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  unidad_condicion_banderas_if #(.N(32)) bus ();
  unidad_condicion_banderas #(.N(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  typedef struct {
    logic [3:0] cond;
    logic       upd;
    logic       esc;
    logic [3:0] bi;
    logic       xe;
    logic [3:0] xb;
    logic [7:0] xa;
    logic       xi;
  } vec_t;
  vec_t v[18];
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic drive(input logic iv, input logic ordy, input logic [3:0] cnd, input logic upd,
                       input logic esc, input logic [3:0] bi, input logic [31:0] res, input logic [3:0] rdi);
    bus.in_valid = iv; bus.out_ready = ordy; bus.cond = cnd; bus.actualiza_ban = upd;
    bus.escribe_in = esc; bus.ban_in = bi; bus.resultado = res; bus.rd = rdi;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] held;
    v[0]  = '{4'hE, 1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 8'd0, 1'b0};
    v[1]  = '{4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0100, 8'd0, 1'b0};
    v[2]  = '{4'h1, 1'b1, 1'b1, 4'b1000, 1'b0, 4'b0100, 8'd1, 1'b0};
    v[3]  = '{4'h8, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0100, 8'd2, 1'b0};
    v[4]  = '{4'h9, 1'b1, 1'b1, 4'b0010, 1'b1, 4'b0010, 8'd2, 1'b0};
    v[5]  = '{4'h8, 1'b1, 1'b1, 4'b1000, 1'b1, 4'b1000, 8'd2, 1'b0};
    v[6]  = '{4'hB, 1'b1, 1'b1, 4'b1001, 1'b1, 4'b1001, 8'd2, 1'b0};
    v[7]  = '{4'hA, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1001, 8'd2, 1'b0};
    v[8]  = '{4'hD, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1001, 8'd3, 1'b0};
    v[9]  = '{4'hC, 1'b1, 1'b1, 4'b0001, 1'b1, 4'b0001, 8'd3, 1'b0};
    v[10] = '{4'h6, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 8'd3, 1'b0};
    v[11] = '{4'h7, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 8'd4, 1'b0};
    v[12] = '{4'h4, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 8'd5, 1'b0};
    v[13] = '{4'h5, 1'b1, 1'b1, 4'b0110, 1'b1, 4'b0110, 8'd5, 1'b0};
    v[14] = '{4'h2, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0110, 8'd5, 1'b0};
    v[15] = '{4'h3, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0110, 8'd6, 1'b0};
    v[16] = '{4'hF, 1'b1, 1'b1, 4'b1111, 1'b0, 4'b0110, 8'd7, 1'b1};
    v[17] = '{4'hE, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0110, 8'd7, 1'b1};
    drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    tick; tick;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_banderas", {28'd0, bus.banderas}, 32'd0);
    chk("rst_anuladas", {24'd0, bus.anuladas}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 1'b1, v[i].cond, v[i].upd, v[i].esc, v[i].bi, (i == 0) ? 32'h0 : 32'hA000_0000 + i, 4'(i));
      tick;
      chk($sformatf("v%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("v%0d_out_escribe", i), {31'd0, bus.out_escribe}, {31'd0, v[i].xe});
      chk($sformatf("v%0d_banderas", i), {28'd0, bus.banderas}, {28'd0, v[i].xb});
      chk($sformatf("v%0d_anuladas", i), {24'd0, bus.anuladas}, {24'd0, v[i].xa});
      chk($sformatf("v%0d_cond_invalida", i), {31'd0, bus.cond_invalida}, {31'd0, v[i].xi});
      chk($sformatf("v%0d_out_resultado", i), bus.out_resultado, (i == 0) ? 32'h0 : 32'hA000_0000 + i);
      chk($sformatf("v%0d_out_rd", i), {28'd0, bus.out_rd}, 32'(i % 16));
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 4'hE, 1'b0, 1'b1, 4'h0, 32'h100 + i, 4'h3);
      tick;
      chk($sformatf("sticky%0d_cond_invalida", i), {31'd0, bus.cond_invalida}, 32'd1);
    end
    held = 32'h100 + 9;
    drive(1'b1, 1'b0, 4'hE, 1'b0, 1'b1, 4'h0, 32'hDEAD_BEEF, 4'h7);
    #1;
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("bp%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd0);
      chk($sformatf("bp%0d_out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp%0d_out_resultado", i), bus.out_resultado, held);
    end
    bus.out_ready = 1'b1;
    tick;
    chk("bp_reload_out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("bp_reload_out_resultado", bus.out_resultado, 32'hDEAD_BEEF);
    chk("bp_reload_out_rd", {28'd0, bus.out_rd}, 32'd7);
    bus.in_valid = 1'b0;
    tick;
    chk("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("drain_out_resultado", bus.out_resultado, 32'hDEAD_BEEF);
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 4'h0, 32'(i), 4'h1);
      tick;
      if (i == 246) chk("sat_anuladas_254", {24'd0, bus.anuladas}, 32'd254);
    end
    chk("sat_anuladas", {24'd0, bus.anuladas}, 32'd255);
    chk("sat_out_escribe", {31'd0, bus.out_escribe}, 32'd0);
    drive(1'b1, 1'b1, 4'hE, 1'b1, 1'b1, 4'b1111, 32'h5555, 4'h9);
    tick;
    chk("pre_rst_banderas", {28'd0, bus.banderas}, 32'hF);
    chk("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("post_rst_banderas", {28'd0, bus.banderas}, 32'd0);
    chk("post_rst_anuladas", {24'd0, bus.anuladas}, 32'd0);
    chk("post_rst_cond_invalida", {31'd0, bus.cond_invalida}, 32'd0);
    chk("post_rst_out_resultado", bus.out_resultado, 32'd0);
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/unidad_condicion_banderas.md
UNIDAD_CONDICION_BANDERAS -- requirements
Module: unidad_condicion_banderas

Interface
REQ-001 SHALL have parameter N, 32, data width of the ALU result.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream ALU stage presents an operation.
REQ-005 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-006 SHALL have port resultado  input  N  ALU result C.
REQ-007 SHALL have port ban_in  input  4  ALU flags {negativo, cero, acarreo, desborde} (N,Z,C,V).
REQ-008 SHALL have port cond  input  4  condition code of the operation.
REQ-009 SHALL have port actualiza_ban  input  1  operation requests a flag update (S bit).
REQ-010 SHALL have port escribe_in  input  1  operation intends a register write.
REQ-011 SHALL have port rd  input  4  destination register index.
REQ-012 SHALL have port out_valid  output  1  output register holds an entry.
REQ-013 SHALL have port out_ready  input  1  downstream (writeback) accepts.
REQ-014 SHALL have port out_resultado  output  N  registered result.
REQ-015 SHALL have port out_rd  output  4  registered destination.
REQ-016 SHALL have port out_escribe  output  1  registered write enable, gated by condition.
REQ-017 SHALL have port banderas  output  4  architectural NZCV flag register.
REQ-018 SHALL have port anuladas  output  8  count of annulled operations, saturating.
REQ-019 SHALL have port cond_invalida  output  1  sticky: a reserved condition was accepted.

Function
REQ-020 SHALL assert in_ready = !out_valid || out_ready (one-entry pipeline register, no combinational in_valid->in_ready path).
REQ-021 SHALL accept an operation when in_valid && in_ready; latency accept -> out_valid is exactly 1 cycle.
REQ-022 SHALL evaluate cond against banderas as held at the accept cycle (flags of all earlier accepted operations already applied).
REQ-023 SHALL decode cond: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F reserved, treated as false.
REQ-024 SHALL, on accept with condition true and actualiza_ban=1, load banderas <= ban_in at that edge; otherwise banderas unchanged.
REQ-025 SHALL, on accept, load out_resultado <= resultado, out_rd <= rd, out_escribe <= escribe_in && condition true.
REQ-026 SHALL, on accept with condition false, increment anuladas by 1, saturating at 255.
REQ-027 SHALL, on accept with cond=4'hF, set cond_invalida=1, held until reset.
REQ-028 SHALL clear out_valid when out_valid && out_ready && !(in_valid && in_ready); simultaneous drain and accept keeps out_valid=1 with the new entry.
REQ-029 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-030 SHALL make back-to-back accepts see flags written by the immediately preceding accept (no stale-flag bubble).

Reset
REQ-031 SHALL, when rst_n=0 at a rising edge, set out_valid=0, out_resultado=0, out_rd=0, out_escribe=0, banderas=4'b0000, anuladas=0, cond_invalida=0.
REQ-032 SHALL drop any held entry on reset mid-transfer; in_ready SHALL read 1 in the first cycle after reset release.

Structure
REQ-033 SHALL place the condition-code enum (EQ..AL, reservado), NZCV bit-position constants and the flags struct in shared package cpu_pkg.
REQ-034 SHALL implement condition decoding in one combinational sub-module evaluador_condicion (inputs cond, banderas; output cumple).

Verification
REQ-035 SHALL cover: resultado=0, ban_in=0100, cond=E, actualiza_ban=1 -> banderas=0100 next cycle; then cond=0 (EQ), escribe_in=1 -> out_escribe=1.
REQ-036 SHALL cover: with banderas=0100, cond=1 (NE), actualiza_ban=1, ban_in=1000 -> out_escribe=0, banderas stays 0100, anuladas=1.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_resultado constant; out_ready=1 with in_valid=1 -> new entry loaded same edge, out_valid stays 1.
REQ-038 SHALL cover: cond=F accepted -> out_escribe=0, cond_invalida=1 persisting across 10 further operations.
REQ-039 SHALL cover: 260 annulled operations -> anuladas=255.
REQ-040 SHALL cover: rst_n=0 one cycle while out_valid=1, banderas=1111 -> out_valid=0, banderas=0000, anuladas=0.
